// File: rtl/cbrt_seq.sv
// cbrt_seq: sequential integer cube root, y = floor(cbrt(a)), rem = a - y^3.
// Digit-by-digit, one root bit per pass (MSB first), using an internal
// shift-add multiplier to form 3y(y+1).
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-low reset
//   a_i      unsigned operand, sampled on an accepted start
//   start_i  request, accepted only when idle and abort_i is low
//   abort_i  synchronous abort of a running computation
//   busy_o   high while a computation is in progress
//   valid_o  one-cycle strobe: y_bo/rem_bo just updated
//   y_bo     root result (RW = (WIDTH+2)/3 bits), held until next completion
//   rem_bo   remainder a - y^3, held until next completion
module cbrt_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         a_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [(WIDTH+2)/3-1:0]   y_bo,
  output logic [WIDTH-1:0]         rem_bo
);

  localparam int unsigned RW = (WIDTH + 2) / 3;
  localparam int unsigned CW = 3 * RW + 2;
  localparam int unsigned SW = $clog2(RW + 1);

  typedef enum logic [2:0] {IDLE, ITER, MUL, CHECK, FINISH} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x;
  logic [RW-1:0]    y;
  logic [RW-1:0]    y2;
  logic [SW-1:0]    step;
  logic [SW-1:0]    cnt;
  logic [CW-1:0]    mcand;
  logic [RW-1:0]    mplier;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    x_ext;
  logic [CW-1:0]    b;
  logic             fit;
  logic             kill;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i && !abort_i) state_nx = ITER;
      ITER:    state_nx = MUL;
      MUL:     if (cnt == '0) state_nx = CHECK;
      CHECK:   state_nx = (step == '0) ? FINISH : ITER;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && abort_i) state_nx = IDLE;
  end

  // Output logic
  always_comb begin
    busy_o = (state != IDLE);
  end

  // Datapath helpers; b is formed at full 3*RW+2 width so nothing is lost.
  always_comb begin
    kill  = abort_i && (state != IDLE);
    y2    = y << 1;
    x_ext = CW'(x);
    b     = (acc + CW'(1)) << (3 * step);
    fit   = (x_ext >= b);
  end

  // Datapath registers. The final CHECK result is published one cycle later
  // from FINISH so completion lands RW*(RW+2)+1 edges after acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x       <= '0;
      y       <= '0;
      step    <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      y_bo    <= '0;
      rem_bo  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!kill) begin
        case (state)
          IDLE: begin
            if (start_i && !abort_i) begin
              x    <= a_i;
              y    <= '0;
              step <= SW'(RW - 1);
            end
          end
          ITER: begin
            y      <= y2;
            mcand  <= (CW'(y2) << 1) + CW'(y2);
            mplier <= y2 | RW'(1);
            acc    <= '0;
            cnt    <= SW'(RW - 1);
          end
          MUL: begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - SW'(1);
          end
          CHECK: begin
            if (fit) begin
              x <= WIDTH'(x_ext - b);
              y <= y + RW'(1);
            end
            if (step != '0) step <= step - SW'(1);
          end
          FINISH: begin
            y_bo    <= y;
            rem_bo  <= x;
            valid_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cbrt_seq.sv
// tb_cbrt_seq: scoreboard bench for cbrt_seq at WIDTH=8 and WIDTH=16.
// Expected results are pushed on accepted starts and compared when valid_o
// strobes; latency is checked from the acceptance edge.
module tb_cbrt_seq;

  typedef struct {
    int unsigned a;
    int unsigned y;
    int unsigned r;
    longint      t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8;
  logic        start8, abort8;
  logic        busy8, valid8;
  logic [2:0]  y8;
  logic [7:0]  rem8;
  logic [15:0] a16;
  logic        start16, abort16;
  logic        busy16, valid16;
  logic [5:0]  y16;
  logic [15:0] rem16;

  exp_t sb8[$];
  exp_t sb16[$];
  int   total = 0;
  int   bad = 0;
  bit   v8_d = 1'b0;
  bit   v16_d = 1'b0;

  always #5 clk = ~clk;

  cbrt_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .a_i(a8), .start_i(start8), .abort_i(abort8),
    .busy_o(busy8), .valid_o(valid8), .y_bo(y8), .rem_bo(rem8)
  );

  cbrt_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .a_i(a16), .start_i(start16), .abort_i(abort16),
    .busy_o(busy16), .valid_o(valid16), .y_bo(y16), .rem_bo(rem16)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned icbrt(input int unsigned a);
    int unsigned y = 0;
    while ((y + 1) * (y + 1) * (y + 1) <= a) y++;
    return y;
  endfunction

  function automatic exp_t model(input int unsigned a);
    exp_t e;
    e.a = a;
    e.y = icbrt(a);
    e.r = a - e.y * e.y * e.y;
    e.t = longint'($time);
    return e;
  endfunction

  // Start is driven now and accepted on the next rising edge (DUT must be idle).
  task automatic go8(input logic [7:0] a, input bit push);
    a8 = a;
    start8 = 1'b1;
    @(posedge clk);
    if (push) sb8.push_back(model(int'(a)));
    #1 start8 = 1'b0;
    chk("busy8 after start", longint'(busy8), 1);
  endtask

  task automatic go16(input logic [15:0] a);
    a16 = a;
    start16 = 1'b1;
    @(posedge clk);
    sb16.push_back(model(int'(a)));
    #1 start16 = 1'b0;
    chk("busy16 after start", longint'(busy16), 1);
  endtask

  task automatic wait_valid8();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = valid8;
    end
    chk("valid8 within bound", longint'(seen), 1);
  endtask

  task automatic wait_valid16();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = valid16;
    end
    chk("valid16 within bound", longint'(seen), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid8) begin
      chk("sb8 has entry at valid", longint'(sb8.size() > 0), 1);
      chk("valid8 one cycle", longint'(v8_d), 0);
      chk("busy8 low at valid", longint'(busy8), 0);
      if (sb8.size() > 0) begin
        e = sb8.pop_front();
        chk("y8", longint'(y8), longint'(e.y));
        chk("rem8", longint'(rem8), longint'(e.r));
        chk("cube8", longint'(y8) ** 3 + longint'(rem8), longint'(e.a));
        chk("lat8", (longint'($time) - e.t - 5) / 10, 16);
      end
    end
    v8_d = valid8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid16) begin
      chk("sb16 has entry at valid", longint'(sb16.size() > 0), 1);
      chk("valid16 one cycle", longint'(v16_d), 0);
      if (sb16.size() > 0) begin
        e = sb16.pop_front();
        chk("y16", longint'(y16), longint'(e.y));
        chk("rem16", longint'(rem16), longint'(e.r));
        chk("lat16", (longint'($time) - e.t - 5) / 10, 49);
      end
    end
    v16_d = valid16;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir8 [4];
    int         nv;
    dir8 = '{8'd0, 8'd64, 8'd63, 8'd255};
    rst = 1'b1; a8 = '0; start8 = 1'b0; abort8 = 1'b0;
    a16 = '0; start16 = 1'b0; abort16 = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset busy8", longint'(busy8), 0);
    chk("reset valid8", longint'(valid8), 0);
    chk("reset y8", longint'(y8), 0);
    chk("reset rem8", longint'(rem8), 0);
    chk("reset busy16", longint'(busy16), 0);
    chk("reset rem16", longint'(rem16), 0);
    #10 rst = 1'b1;
    @(negedge clk);

    // Directed values, then exhaustive back-to-back sweep
    for (int i = 0; i < 4; i++) begin
      go8(dir8[i], 1'b1);
      wait_valid8();
    end
    for (int i = 0; i < 256; i++) begin
      go8(8'(i), 1'b1);
      wait_valid8();
    end

    // Start while busy: mid-operation and in the completion cycle
    go8(8'd100, 1'b1);
    repeat (4) @(posedge clk);
    #1 a8 = 8'd200; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (10) @(posedge clk);
    #1 a8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("busy8 stays low after ignored start", longint'(busy8), 0);
    end

    // Abort mid-operation: outputs keep the a=100 result (4, 36)
    go8(8'd255, 1'b0);
    repeat (4) @(posedge clk);
    #1 abort8 = 1'b1;
    @(posedge clk);
    #1 abort8 = 1'b0;
    chk("abort busy8", longint'(busy8), 0);
    chk("abort valid8", longint'(valid8), 0);
    chk("abort y8 held", longint'(y8), 4);
    chk("abort rem8 held", longint'(rem8), 36);
    nv = 0;
    repeat (25) begin @(negedge clk); nv += int'(valid8); end
    chk("abort no valid", longint'(nv), 0);

    // Start together with abort in idle is not accepted
    a8 = 8'd27; start8 = 1'b1; abort8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; abort8 = 1'b0;
    chk("start+abort busy8", longint'(busy8), 0);
    nv = 0;
    repeat (20) begin @(negedge clk); nv += int'(valid8); end
    chk("start+abort no valid", longint'(nv), 0);

    // Asynchronous reset mid-operation, between edges
    go8(8'd200, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midreset busy8", longint'(busy8), 0);
    chk("midreset valid8", longint'(valid8), 0);
    chk("midreset y8", longint'(y8), 0);
    chk("midreset rem8", longint'(rem8), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    go8(8'd125, 1'b1);
    wait_valid8();
    go8(8'd130, 1'b1);
    wait_valid8();

    // WIDTH=16
    go16(16'd65535);
    wait_valid16();
    go16(16'd32768);
    wait_valid16();
    go16(16'd27000);
    wait_valid16();

    repeat (3) @(negedge clk);
    chk("sb8 drained", longint'(sb8.size()), 0);
    chk("sb16 drained", longint'(sb16.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
